// File: rtl/fp_div_seq.sv
// ============================================================================
// fp_div_seq : sequential IEEE 754 single-precision divider (restoring, 1 bit/cycle)
// Optional macro FP_DIV_ROUND_EN enables round-to-nearest-even (default truncates).
// Revision 1.0
// ============================================================================
`default_nettype none

module fp_div_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    NORM = 3'd1,
    DIV  = 3'd2,
    PACK = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [31:0] C_QNAN = 32'h7FC00000;

  state_t             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [31:0]        result_q, result_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic               sign_q, sign_d;
  logic signed [9:0]  ea_q, ea_d, eb_q, eb_d;
  logic [23:0]        ma_q, ma_d, mb_q, mb_d;
  logic [24:0]        rem_q, rem_d;
  logic [25:0]        quo_q, quo_d;
  logic [4:0]         cnt_q, cnt_d;

  // Returns {exponent(10, signed), mantissa(24) as 1.f}; denormals are
  // left-justified by a priority encoder and get exponent 1 - shift.
  function automatic logic [33:0] unpack(input logic [30:0] x);
    logic [4:0]  sh;
    logic [23:0] m;
    logic [9:0]  e;
    sh = 5'd0;
    for (int i = 0; i < 23; i++) begin
      if (x[i]) sh = 5'(23 - i);
    end
    if (x[30:23] == 8'd0) begin
      m = {1'b0, x[22:0]} << sh;
      e = 10'd1 - {5'd0, sh};
    end else begin
      m = {1'b1, x[22:0]};
      e = {2'b00, x[30:23]};
    end
    return {e, m};
  endfunction

  logic [33:0]       ua, ub;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic              q_bit;
  logic [24:0]       rem_sub, rem_next;
  logic signed [9:0] e_pk;
  logic [22:0]       mant;
`ifdef FP_DIV_ROUND_EN
  logic              guard, sticky, round_up;
  logic [23:0]       mant_rnd;
`endif

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    a_d         = a_q;
    b_d         = b_q;
    sign_d      = sign_q;
    ea_d        = ea_q;
    eb_d        = eb_q;
    ma_d        = ma_q;
    mb_d        = mb_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;

    ua      = unpack(a_q[30:0]);
    ub      = unpack(b_q[30:0]);
    a_nan   = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
    b_nan   = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
    a_inf   = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
    b_inf   = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
    a_zero  = (a_q[30:0] == 31'd0);
    b_zero  = (b_q[30:0] == 31'd0);

    q_bit    = (rem_q >= {1'b0, mb_q});
    rem_sub  = rem_q - {1'b0, mb_q};
    rem_next = q_bit ? rem_sub : rem_q;

    // Quotient lies in (0.5, 2): a clear integer bit means one left shift.
    e_pk = ea_q - eb_q + 10'sd127;
    if (!quo_q[25]) e_pk = e_pk - 10'sd1;
    mant = quo_q[25] ? quo_q[24:2] : quo_q[23:1];
`ifdef FP_DIV_ROUND_EN
    guard    = quo_q[25] ? quo_q[1] : quo_q[0];
    sticky   = (quo_q[25] & quo_q[0]) | (rem_q != 25'd0);
    round_up = guard & (sticky | mant[0]);
    mant_rnd = {1'b0, mant} + {23'd0, round_up};
    mant     = mant_rnd[22:0];
    if (mant_rnd[23]) e_pk = e_pk + 10'sd1;
`endif

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          state_d = NORM;
        end
      end
      NORM: begin
        sign_d = a_q[31] ^ b_q[31];
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
          result_d    = C_QNAN;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else if (b_zero || a_inf) begin
          result_d    = {a_q[31] ^ b_q[31], 8'hFF, 23'd0};
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else if (a_zero || b_inf) begin
          result_d    = {a_q[31] ^ b_q[31], 31'd0};
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          ea_d    = ua[33:24];
          ma_d    = ua[23:0];
          eb_d    = ub[33:24];
          mb_d    = ub[23:0];
          rem_d   = {1'b0, ua[23:0]};
          quo_d   = 26'd0;
          cnt_d   = 5'd0;
          state_d = DIV;
        end
      end
      DIV: begin
        quo_d = {quo_q[24:0], q_bit};
        rem_d = rem_next << 1;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd25) state_d = PACK;
      end
      PACK: begin
        if (e_pk >= 10'sd255)    result_d = {sign_q, 8'hFF, 23'd0};
        else if (e_pk <= 10'sd0) result_d = {sign_q, 31'd0};
        else                     result_d = {sign_q, e_pk[7:0], mant};
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= 32'd0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      sign_q      <= 1'b0;
      ea_q        <= 10'sd0;
      eb_q        <= 10'sd0;
      ma_q        <= 24'd0;
      mb_q        <= 24'd0;
      rem_q       <= 25'd0;
      quo_q       <= 26'd0;
      cnt_q       <= 5'd0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sign_q      <= sign_d;
      ea_q        <= ea_d;
      eb_q        <= eb_d;
      ma_q        <= ma_d;
      mb_q        <= mb_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_div_seq.sv
// ============================================================================
// tb_fp_div_seq : directed, table-driven self-checking bench for fp_div_seq
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_fp_div_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;

  fp_div_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

`ifdef FP_DIV_ROUND_EN
  localparam logic [31:0] C_THIRD     = 32'h3EAAAAAB;
  localparam logic [31:0] C_TWO_THIRD = 32'h3F2AAAAB;
`else
  localparam logic [31:0] C_THIRD     = 32'h3EAAAAAA;
  localparam logic [31:0] C_TWO_THIRD = 32'h3F2AAAAA;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h required=%08h", nm, act, exp);
    end
  endtask

  // Accept one operand pair, then measure cycles (accept cycle = T) to out_valid.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic [31:0] ex, input int lat, input string nm);
    int n;
    @(negedge clk);
    chk({nm, " in_ready_idle"}, 32'(in_ready), 32'd1);
    a = ta;
    b = tb_v;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 32'd0;
    b = 32'd0;
    chk({nm, " in_ready_busy"}, 32'(in_ready), 32'd0);
    n = 1;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, " latency"}, 32'(n), 32'(lat));
    chk({nm, " result"}, result, ex);
  endtask

  task automatic handshake(input string nm);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({nm, " hs_out_valid"}, 32'(out_valid), 32'd0);
    chk({nm, " hs_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t   vecs[16];
    int     n;
    logic [31:0] held;

    vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 29};
    vecs[1]  = '{32'h3F800000, 32'h40400000, C_THIRD,      29};
    vecs[2]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 2};
    vecs[3]  = '{32'hBF800000, 32'h00000000, 32'hFF800000, 2};
    vecs[4]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 2};
    vecs[5]  = '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 2};
    vecs[6]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 2};
    vecs[7]  = '{32'h7F000000, 32'h3F000000, 32'h7F800000, 29};
    vecs[8]  = '{32'h00800000, 32'h40000000, 32'h00000000, 29};
    vecs[9]  = '{32'h00400000, 32'h3F000000, 32'h00800000, 29};
    vecs[10] = '{32'hC0C00000, 32'h40000000, 32'hC0400000, 29};
    vecs[11] = '{32'h3F800000, 32'h7F800000, 32'h00000000, 2};
    vecs[12] = '{32'hFF800000, 32'h3F800000, 32'hFF800000, 2};
    vecs[13] = '{32'h80000000, 32'h3F800000, 32'h80000000, 2};
    vecs[14] = '{32'h40000000, 32'hC0000000, 32'hBF800000, 29};
    vecs[15] = '{32'h40000000, 32'h40400000, C_TWO_THIRD,  29};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, $sformatf("vec%0d", i));
      handshake($sformatf("vec%0d", i));
    end

    // Backpressure in DONE with in_valid noise that must be ignored
    run_op(32'h40C00000, 32'h40000000, 32'h40400000, 29, "hold");
    held = 32'h40400000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = 32'h3F800000;
      b = 32'h3F800000;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("hold%0d result", k), result, held);
      chk($sformatf("hold%0d out_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("hold%0d in_ready", k), 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = 32'd0;
    b = 32'd0;
    chk("hold release in_ready", 32'(in_ready), 32'd1);
    chk("hold release out_valid", 32'(out_valid), 32'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("post_hs no_accept in_ready", 32'(in_ready), 32'd1);
      chk("post_hs out_valid", 32'(out_valid), 32'd0);
    end

    // Reset at T+10 aborts the operation; new accept at T+12 completes
    @(negedge clk);
    a = 32'h40C00000;
    b = 32'h40000000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 1;
    while (n < 10) begin
      @(posedge clk);
      #1;
      n++;
      chk($sformatf("abort c%0d out_valid", n), 32'(out_valid), 32'd0);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("abort post_rst out_valid", 32'(out_valid), 32'd0);
    chk("abort post_rst in_ready", 32'(in_ready), 32'd1);
    chk("abort post_rst result", result, 32'd0);
    @(posedge clk);
    #1;
    chk("abort T+12 out_valid", 32'(out_valid), 32'd0);
    run_op(32'h3F800000, 32'h40400000, C_THIRD, 29, "after_rst");
    handshake("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
